hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, max MEM_WAIT cycles before fault (range 2..255).
REQ-002 SHALL have parameter CNT_W, default 16, width of performance counters.
REQ-003 SHALL have port clk  input  1  single rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports id_rs1, id_rs2  input  5 each  source registers of instruction in ID.
REQ-006 SHALL have ports id_uses_rs1, id_uses_rs2  input  1 each  ID instruction reads rs1/rs2.
REQ-007 SHALL have ports ex_is_load  input  1, ex_rd  input  5  load in EX and its destination.
REQ-008 SHALL have port ex_redirect  input  1  taken branch/JAL/JALR resolved in EX.
REQ-009 SHALL have ports mem_req  input  1, dmem_ready  input  1  MEM-stage data access and memory completion.
REQ-010 SHALL have port perf_clear  input  1  synchronous clear of counters.
REQ-011 SHALL have ports pc_we, ifid_we, idex_we, exmem_we  output  1 each  stage register enables.
REQ-012 SHALL have ports ifid_flush, idex_flush, memwb_bubble  output  1 each  insert NOP into IF/ID, ID/EX, MEM/WB.
REQ-013 SHALL have ports mem_fault  output  1  sticky timeout; stall_cycles, flush_count  output  CNT_W each.

Function
REQ-014 SHALL implement FSM states RUN, MEM_WAIT, FAULT plus wait counter wcnt (8 bits).
REQ-015 Freeze condition SHALL be (RUN & mem_req & ~dmem_ready) | (MEM_WAIT & ~dmem_ready); stall takes effect the same cycle (combinational, zero latency).
REQ-016 During freeze: pc_we=ifid_we=idex_we=exmem_we=0, memwb_bubble=1, ifid_flush=idex_flush=0; ex_redirect and load-use ignored.
REQ-017 Load-use hazard SHALL be ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-018 Not frozen, ex_redirect=1: pc_we=1, ifid_flush=1, idex_flush=1, all other enables 1; load-use ignored (wrong-path ID).
REQ-019 Not frozen, no redirect, load-use: pc_we=0, ifid_we=0, idex_flush=1, idex_we=1, exmem_we=1; exactly one bubble per hazard.
REQ-020 Otherwise all enables 1, all flush/bubble 0.
REQ-021 RUN->MEM_WAIT when mem_req & ~dmem_ready; wcnt<=1.
REQ-022 MEM_WAIT & dmem_ready -> RUN, wcnt<=0; REQ-018..020 apply that same (release) cycle.
REQ-023 MEM_WAIT & ~dmem_ready: wcnt<=wcnt+1; when wcnt==TIMEOUT -> FAULT.
REQ-024 FAULT: all enables 0, all flush/bubble 0, mem_fault=1; exit only via reset.
REQ-025 stall_cycles SHALL increment each cycle with freeze or load-use stall (not FAULT); flush_count increments each cycle REQ-018 applies.
REQ-026 Counters SHALL saturate at all-ones; perf_clear zeroes both next edge and overrides same-cycle increment.

Reset
REQ-027 rst_n low SHALL asynchronously force state=RUN, wcnt=0, counters=0, mem_fault=0.
REQ-028 While rst_n low, all enables SHALL be 0 and ifid_flush=idex_flush=memwb_bubble=1; reset mid-MEM_WAIT or in FAULT returns to RUN.

Verification
REQ-029 ex_is_load=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for one cycle -> pc_we=0, ifid_we=0, idex_flush=1; stall_cycles=1.
REQ-030 Same load-use plus ex_redirect=1 -> pc_we=1, ifid_flush=1, idex_flush=1; flush_count=1, stall_cycles=0.
REQ-031 ex_rd=0 with matching id_rs1=0 -> no stall, all enables 1.
REQ-032 mem_req=1, dmem_ready=0 for 3 cycles then 1 -> freeze 3 cycles, memwb_bubble=1, RUN on 4th; stall_cycles=3.
REQ-033 TIMEOUT=4, dmem_ready held 0 -> FAULT after 5 freeze cycles, mem_fault=1 stays; rst_n pulse -> RUN, mem_fault=0.
REQ-034 CNT_W=4, 20 load-use stalls -> stall_cycles=15; perf_clear with stall -> 0 next cycle.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard inputs, stage register controls and perf counters of the pipeline
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_is_load, ex_redirect, mem_req, dmem_ready, perf_clear;
  logic pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, memwb_bubble, mem_fault;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  modport master (
    output id_rs1, id_rs2, ex_rd, id_uses_rs1, id_uses_rs2, ex_is_load, ex_redirect,
           mem_req, dmem_ready, perf_clear,
    input  pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, memwb_bubble,
           mem_fault, stall_cycles, flush_count
  );
  modport slave (
    input  id_rs1, id_rs2, ex_rd, id_uses_rs1, id_uses_rs2, ex_is_load, ex_redirect,
           mem_req, dmem_ready, perf_clear,
    output pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, memwb_bubble,
           mem_fault, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control with memory-wait timeout and perf counters
module hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;
  state_t state;
  logic [7:0] wcnt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic fault, freeze, load_use, redirect, lu_stall, run_ok;
  assign fault = state == FAULT;
  assign freeze = (((state == RUN) & hz.mem_req) | (state == MEM_WAIT)) & ~hz.dmem_ready;
  assign load_use = hz.ex_is_load & (|hz.ex_rd) &
                    ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                     (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd)));
  assign run_ok = rst_n & ~fault & ~freeze;
  assign redirect = run_ok & hz.ex_redirect;
  assign lu_stall = run_ok & ~hz.ex_redirect & load_use;
  assign hz.pc_we = run_ok & ~lu_stall;
  assign hz.ifid_we = run_ok & ~lu_stall;
  assign hz.idex_we = run_ok;
  assign hz.exmem_we = run_ok;
  assign hz.ifid_flush = ~rst_n | redirect;
  assign hz.idex_flush = ~rst_n | redirect | lu_stall;
  assign hz.memwb_bubble = ~rst_n | freeze;
  assign hz.mem_fault = fault;
  assign hz.stall_cycles = stall_cnt;
  assign hz.flush_count = flush_cnt;
  // Memory-wait FSM: count wait cycles and latch a fault once the timeout is reached
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      wcnt <= '0;
    end else
      unique case (state)
        RUN: if (freeze) begin
          state <= MEM_WAIT;
          wcnt <= 8'd1;
        end
        MEM_WAIT: if (hz.dmem_ready) begin
          state <= RUN;
          wcnt <= '0;
        end else begin
          wcnt <= wcnt + 8'd1;
          if (wcnt == 8'(TIMEOUT)) state <= FAULT;
        end
        default: state <= FAULT;
      endcase
  // Saturating perf counters; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (hz.perf_clear) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((freeze | lu_stall) && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
endmodule
